ls_unit: RTL and testbench
==========================

LS_UNIT -- requirements
Module: ls_unit

Interface
REQ-001 SHALL have port clk  input  1  single clock; all state updates on posedge clk.
REQ-002 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-003 SHALL have port flush  input  1  squash of in-flight uncommitted work.
REQ-004 SHALL have port start  input  1  accept request from LS queue (to_ls_unit).
REQ-005 SHALL have port insn_in  input  LS_UNIT_PACK  insn and read_write (1 = load, 0 = store); uses value_src1, value_src2, imm, insn_tag, func, mem_size.
REQ-006 SHALL have ports mem_req_valid output 1, mem_req_ready input 1, mem_req_write output 1, mem_req_addr output XLEN, mem_req_wdata output XLEN, mem_req_size output 2 (00 = byte, 01 = half, 10 = word); valid/ready request channel.
REQ-007 SHALL have ports mem_resp_valid input 1 and mem_resp_data input XLEN; load response, always accepted.
REQ-008 SHALL have port done  output 1  one-cycle pulse retiring the LS queue head (done_from_ls_unit).
REQ-009 SHALL have ports cdb_valid output 1, cdb_tag output ROB_TAG_LEN, cdb_value output XLEN; load result broadcast.
REQ-010 SHALL have port busy  output 1  high whenever state is not IDLE.

Function
REQ-011 SHALL implement the states IDLE, REQ, WAIT, COMPLETE and DRAIN.
REQ-012 In IDLE with start=1, SHALL latch insn_in and compute addr = value_src1 + imm (mod 2^XLEN), then go to REQ next cycle.
REQ-013 SHALL ignore start when not in IDLE.
REQ-014 In REQ, SHALL drive mem_req_valid=1 with addr, size and write = ~read_write; wdata = value_src2 with the low bytes placed per size.
REQ-015 SHALL hold all request fields stable until mem_req_ready=1.
REQ-016 On the REQ handshake, a store SHALL go to COMPLETE and a load SHALL go to WAIT.
REQ-017 In WAIT, on mem_resp_valid, SHALL go to COMPLETE and extend the result.
REQ-018 Load result extension: LS_LOAD sign-extends byte/half; LS_LOADU zero-extends; word passes through unchanged.
REQ-019 mem_resp_valid in the same cycle as the handshake SHALL NOT be consumed; a response is only valid from WAIT.
REQ-020 COMPLETE SHALL last exactly one cycle: done=1; for loads also cdb_valid=1, cdb_tag=latched insn_tag, cdb_value=extended data; then IDLE.
REQ-021 Minimum latency: start at cycle N -> store done at N+2 (ready already high); load done at N+3 (response at N+2).
REQ-022 On flush in IDLE or COMPLETE: SHALL go to IDLE and suppress done/cdb_valid that cycle.
REQ-023 On flush in REQ for a load: SHALL drop mem_req_valid the next cycle and go to IDLE.
REQ-024 On flush in REQ for a store (already committed): SHALL finish the handshake, then go to IDLE without pulsing done.
REQ-025 On flush in WAIT: SHALL go to DRAIN; DRAIN discards the next mem_resp_valid, then goes to IDLE with no done/cdb.
REQ-026 A flush arriving while in DRAIN SHALL keep the block in DRAIN.
REQ-027 When idle, outputs SHALL drive cdb_value=0 and cdb_tag=0.

Reset
REQ-028 Reset SHALL dominate flush and start: state=IDLE; mem_req_valid, done, cdb_valid and busy=0; cdb_tag, cdb_value and the latched insn=0.
REQ-029 Reset mid-transaction SHALL abandon the transaction without draining.

Configuration
REQ-030 With `LS_UNIT_MISALIGN_CHECK_EN` defined, a half access at an odd address or a word access with addr[1:0]!=0 SHALL skip memory, go to COMPLETE, and assert an extra output misalign (1 bit) with done.
REQ-031 Without `LS_UNIT_MISALIGN_CHECK_EN`, the misalign port SHALL be absent and the low address bits SHALL pass through to memory unchanged.

Structure
REQ-032 The LS_UNIT_PACK, LS func enum, the mem_size encoding and the state enum SHALL reside in the shared sys_defs/ls_queue header package.
REQ-033 Load data extension SHALL be a sub-module ls_load_align (addr low bits, size, unsigned -> XLEN result).

Verification
REQ-034 Store: start with value_src1=0x1000, imm=8, value_src2=0xDEADBEEF, word, ready=1 -> request addr=0x1008, write=1 at N+1; done at N+2; cdb_valid=0.
REQ-035 LS_LOAD byte at 0x2003 with resp 0x00000080 -> cdb_value=0xFFFFFF80 and cdb_tag matches; the same case with LS_LOADU -> 0x00000080.
REQ-036 Hold mem_req_ready=0 for 3 cycles -> request fields stable; done occurs 3 cycles later.
REQ-037 Flush during WAIT, then response after 2 cycles -> no done/cdb; busy=0 the cycle after the response; a new start is accepted.
REQ-038 start while busy -> ignored; reset asserted in WAIT -> all outputs 0 next cycle.
REQ-039 With `LS_UNIT_MISALIGN_CHECK_EN` defined, a word load at 0x1002 -> no mem_req_valid; done=1 and misalign=1 at N+2.

Source files
------------

// File: rtl/ls_unit_pkg.sv
// Shared LS definitions: instruction pack, function/size encodings, FSM state codes
// and the store-data lane placement helper used by ls_unit.
package ls_unit_pkg;

  localparam int XLEN        = 32;
  localparam int ROB_TAG_LEN = 6;

  typedef enum logic [1:0] {
    LS_LOAD  = 2'b00,
    LS_LOADU = 2'b01,
    LS_STORE = 2'b10
  } ls_func_t;

  typedef enum logic [1:0] {
    MEM_BYTE = 2'b00,
    MEM_HALF = 2'b01,
    MEM_WORD = 2'b10
  } mem_size_t;

  typedef struct packed {
    logic [31:0]            insn;
    logic                   read_write;  // 1 = load, 0 = store
    logic [XLEN-1:0]        value_src1;
    logic [XLEN-1:0]        value_src2;
    logic [XLEN-1:0]        imm;
    logic [ROB_TAG_LEN-1:0] insn_tag;
    ls_func_t               func;
    mem_size_t              mem_size;
  } LS_UNIT_PACK;

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_REQ      = 3'd1;
  localparam logic [2:0] S_WAIT     = 3'd2;
  localparam logic [2:0] S_COMPLETE = 3'd3;
  localparam logic [2:0] S_DRAIN    = 3'd4;

  // Replicate the low bytes across every lane so any byte-enable scheme finds them.
  function automatic logic [XLEN-1:0] place_wdata(input logic [XLEN-1:0] d, input mem_size_t sz);
    case (sz)
      MEM_BYTE: return {(XLEN/8){d[7:0]}};
      MEM_HALF: return {(XLEN/16){d[15:0]}};
      default:  return d;
    endcase
  endfunction

endpackage

// File: rtl/ls_load_align.sv
// ls_load_align: sign/zero extension of a right-justified load response.
module ls_load_align
  import ls_unit_pkg::*;
(
  input  logic [XLEN-1:0] i_data,
  input  logic [1:0]      i_addr_lo,
  input  mem_size_t       i_size,
  input  logic            i_unsigned,
  output logic [XLEN-1:0] o_result
);

  logic w_unused;

  // Memory returns the addressed bytes right-justified, so the offset is not needed here.
  assign w_unused = ^i_addr_lo;

  // Extend byte/half results; words pass through.
  always_comb begin
    o_result = i_data;
    case (i_size)
      MEM_BYTE: begin
        if (i_unsigned) o_result = {{(XLEN-8){1'b0}}, i_data[7:0]};
        else            o_result = {{(XLEN-8){i_data[7]}}, i_data[7:0]};
      end
      MEM_HALF: begin
        if (i_unsigned) o_result = {{(XLEN-16){1'b0}}, i_data[15:0]};
        else            o_result = {{(XLEN-16){i_data[15]}}, i_data[15:0]};
      end
      default: o_result = i_data;
    endcase
  end

endmodule

// File: rtl/ls_unit.sv
// ls_unit: single-outstanding load/store unit between the LS queue and memory.
// Optional feature: define LS_UNIT_MISALIGN_CHECK_EN to trap misaligned half/word accesses (adds port misalign).
module ls_unit
  import ls_unit_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   start,
  input  LS_UNIT_PACK            insn_in,
  output logic                   mem_req_valid,
  input  logic                   mem_req_ready,
  output logic                   mem_req_write,
  output logic [XLEN-1:0]        mem_req_addr,
  output logic [XLEN-1:0]        mem_req_wdata,
  output logic [1:0]             mem_req_size,
  input  logic                   mem_resp_valid,
  input  logic [XLEN-1:0]        mem_resp_data,
  output logic                   done,
  output logic                   cdb_valid,
  output logic [ROB_TAG_LEN-1:0] cdb_tag,
  output logic [XLEN-1:0]        cdb_value,
  output logic                   busy
`ifdef LS_UNIT_MISALIGN_CHECK_EN
  ,
  output logic                   misalign
`endif
);

  logic [2:0]             r_state;
  logic [2:0]             w_next;
  logic [XLEN-1:0]        r_addr;
  logic [XLEN-1:0]        r_wdata;
  logic [XLEN-1:0]        r_result;
  mem_size_t              r_size;
  logic                   r_write;
  logic                   r_load;
  logic                   r_unsigned;
  logic                   r_squash;
  logic                   r_misalign;
  logic [ROB_TAG_LEN-1:0] r_tag;
  logic [XLEN-1:0]        w_addr;
  logic [XLEN-1:0]        w_load_data;
  logic                   w_accept;
  logic                   w_misalign;
  logic                   w_complete;
  logic                   w_unused;

  assign w_addr     = insn_in.value_src1 + insn_in.imm;
  // A flush in IDLE also squashes a start offered in the same cycle.
  assign w_accept   = (r_state == S_IDLE) && start && !flush;
  assign w_complete = (r_state == S_COMPLETE) && !flush;
  assign w_unused   = ^insn_in.insn;

`ifdef LS_UNIT_MISALIGN_CHECK_EN
  assign w_misalign = ((insn_in.mem_size == MEM_HALF) && w_addr[0]) ||
                      ((insn_in.mem_size == MEM_WORD) && (w_addr[1:0] != 2'b00));
  assign misalign   = w_complete && r_misalign;
`else
  assign w_misalign = 1'b0;
`endif

  ls_load_align u_align (
    .i_data     (mem_resp_data),
    .i_addr_lo  (r_addr[1:0]),
    .i_size     (r_size),
    .i_unsigned (r_unsigned),
    .o_result   (w_load_data)
  );

  // Next-state selection.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) w_next = S_REQ;
        else          w_next = S_IDLE;
      end
      S_REQ: begin
        if (r_misalign)                 w_next = (flush || r_squash) ? S_IDLE : S_COMPLETE;
        else if (r_load && flush)       w_next = S_IDLE;
        else if (mem_req_ready)         w_next = r_load ? S_WAIT : ((flush || r_squash) ? S_IDLE : S_COMPLETE);
        else                            w_next = S_REQ;
      end
      S_WAIT: begin
        // A response coinciding with the flush is itself the one being discarded.
        if (flush && mem_resp_valid) w_next = S_IDLE;
        else if (flush)              w_next = S_DRAIN;
        else if (mem_resp_valid)     w_next = S_COMPLETE;
        else                         w_next = S_WAIT;
      end
      S_COMPLETE: w_next = S_IDLE;
      S_DRAIN: begin
        if (mem_resp_valid) w_next = S_IDLE;
        else                w_next = S_DRAIN;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // State and transaction registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_addr     <= {XLEN{1'b0}};
      r_wdata    <= {XLEN{1'b0}};
      r_result   <= {XLEN{1'b0}};
      r_size     <= MEM_BYTE;
      r_write    <= 1'b0;
      r_load     <= 1'b0;
      r_unsigned <= 1'b0;
      r_squash   <= 1'b0;
      r_misalign <= 1'b0;
      r_tag      <= {ROB_TAG_LEN{1'b0}};
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_addr     <= w_addr;
        r_wdata    <= place_wdata(insn_in.value_src2, insn_in.mem_size);
        r_size     <= insn_in.mem_size;
        r_write    <= ~insn_in.read_write;
        r_load     <= insn_in.read_write;
        r_unsigned <= (insn_in.func == LS_LOADU);
        r_tag      <= insn_in.insn_tag;
        r_misalign <= w_misalign;
        r_squash   <= 1'b0;
      end
      // A squashed store still owes memory its handshake; remember not to retire it.
      if ((r_state == S_REQ) && flush) r_squash <= 1'b1;
      if ((r_state == S_WAIT) && mem_resp_valid && !flush) r_result <= w_load_data;
    end
  end

  assign mem_req_valid = (r_state == S_REQ) && !r_misalign;
  assign mem_req_write = r_write;
  assign mem_req_addr  = r_addr;
  assign mem_req_wdata = r_wdata;
  assign mem_req_size  = r_size;
  assign done          = w_complete;
  assign cdb_valid     = w_complete && r_load && !r_misalign;
  assign cdb_tag       = cdb_valid ? r_tag : {ROB_TAG_LEN{1'b0}};
  assign cdb_value     = cdb_valid ? r_result : {XLEN{1'b0}};
  assign busy          = (r_state != S_IDLE);

endmodule

// File: tb/tb_ls_unit.sv
// Self-checking bench for ls_unit: directed table, randomized transactions against
// a spec-level model, and hand-written flush/reset/misalign sequences.
module tb_ls_unit;
  import ls_unit_pkg::*;

  typedef struct {
    logic                   ld;
    ls_func_t               fn;
    mem_size_t              sz;
    logic [31:0]            src1, imm, src2, resp;
    logic [ROB_TAG_LEN-1:0] tag;
    logic [31:0]            exp_addr, exp_wdata, exp_val;
    int                     rdly, respdly;
  } vec_t;

  logic                   clk = 1'b0;
  logic                   reset, flush, start;
  LS_UNIT_PACK            insn_in;
  logic                   mem_req_valid, mem_req_ready, mem_req_write;
  logic [XLEN-1:0]        mem_req_addr, mem_req_wdata;
  logic [1:0]             mem_req_size;
  logic                   mem_resp_valid;
  logic [XLEN-1:0]        mem_resp_data;
  logic                   done, cdb_valid, busy;
  logic [ROB_TAG_LEN-1:0] cdb_tag;
  logic [XLEN-1:0]        cdb_value;
`ifdef LS_UNIT_MISALIGN_CHECK_EN
  logic                   misalign;
`endif

  int   checks = 0;
  int   errors = 0;
  vec_t tbl [8];

  always #5 clk = ~clk;

  ls_unit dut (
    .clk(clk), .reset(reset), .flush(flush), .start(start), .insn_in(insn_in),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_write(mem_req_write),
    .mem_req_addr(mem_req_addr), .mem_req_wdata(mem_req_wdata), .mem_req_size(mem_req_size),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
    .done(done), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value), .busy(busy)
`ifdef LS_UNIT_MISALIGN_CHECK_EN
    , .misalign(misalign)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mkv(input logic ld, input ls_func_t fn, input mem_size_t sz,
                               input logic [31:0] src1, input logic [31:0] imm, input logic [31:0] src2,
                               input logic [31:0] resp, input logic [ROB_TAG_LEN-1:0] tag,
                               input logic [31:0] ea, input logic [31:0] ew, input logic [31:0] ev,
                               input int rdly, input int respdly);
    vec_t v;
    v.ld = ld; v.fn = fn; v.sz = sz; v.src1 = src1; v.imm = imm; v.src2 = src2; v.resp = resp;
    v.tag = tag; v.exp_addr = ea; v.exp_wdata = ew; v.exp_val = ev; v.rdly = rdly; v.respdly = respdly;
    return v;
  endfunction

  function automatic LS_UNIT_PACK mk(input vec_t v);
    LS_UNIT_PACK p;
    p.insn = $urandom(); p.read_write = v.ld; p.value_src1 = v.src1; p.value_src2 = v.src2;
    p.imm = v.imm; p.insn_tag = v.tag; p.func = v.fn; p.mem_size = v.sz;
    return p;
  endfunction

  // Reference: store data is the low bytes copied into every lane.
  function automatic logic [31:0] m_wdata(input logic [31:0] d, input mem_size_t sz);
    if (sz == MEM_BYTE)      return (d % 32'd256) * 32'h01010101;
    else if (sz == MEM_HALF) return (d % 32'd65536) * 32'h00010001;
    else                     return d;
  endfunction

  // Reference: load extension as two's-complement arithmetic on the narrow value.
  function automatic logic [31:0] m_load(input logic [31:0] d, input mem_size_t sz, input logic uns);
    logic [31:0] v;
    if (sz == MEM_BYTE) begin
      v = d % 32'd256;
      if (!uns && v >= 32'd128) v = v - 32'd256;
    end else if (sz == MEM_HALF) begin
      v = d % 32'd65536;
      if (!uns && v >= 32'd32768) v = v - 32'd65536;
    end else begin
      v = d;
    end
    return v;
  endfunction

  task automatic cyc(input logic rdy, input logic rv, input logic [31:0] rd, input logic fl, input logic rs);
    @(negedge clk);
    start = 1'b0; mem_req_ready = rdy; mem_resp_valid = rv; mem_resp_data = rd; flush = fl; reset = rs;
    #1;
  endtask

  task automatic begin_txn(input vec_t v);
    @(negedge clk);
    start = 1'b1; insn_in = mk(v); mem_req_ready = 1'b0; mem_resp_valid = 1'b0; flush = 1'b0; reset = 1'b0;
    #1;
    chk("idle_busy", 32'(busy), 32'd0);
  endtask

  // Full transaction with spec latencies: handshake at H, store done H+1, load response R, done R+1.
  task automatic run_txn(input vec_t v, input logic noise);
    int h, r, d;
    h = 1 + v.rdly;
    r = h + 1 + v.respdly;
    d = v.ld ? r + 1 : h + 1;
    begin_txn(v);
    for (int k = 1; k <= d + 1; k++) begin
      @(negedge clk);
      start = noise && (k < d);
      if (noise) begin
        insn_in.value_src1 = $urandom(); insn_in.value_src2 = $urandom();
        insn_in.read_write = ~insn_in.read_write; insn_in.insn_tag = insn_in.insn_tag + 6'd1;
      end
      mem_req_ready  = (k >= h);
      mem_resp_valid = v.ld && ((k == h) || (k == r));
      mem_resp_data  = (k == r) ? v.resp : ~v.resp;
      #1;
      chk("req_valid", 32'(mem_req_valid), 32'(k <= h));
      if (k <= h) begin
        chk("req_addr", mem_req_addr, v.exp_addr);
        chk("req_wdata", mem_req_wdata, v.exp_wdata);
        chk("req_size", 32'(mem_req_size), 32'(v.sz));
        chk("req_write", 32'(mem_req_write), 32'(!v.ld));
      end
      chk("done", 32'(done), 32'(k == d));
      chk("cdb_valid", 32'(cdb_valid), 32'((k == d) && v.ld));
      chk("busy", 32'(busy), 32'(k <= d));
`ifdef LS_UNIT_MISALIGN_CHECK_EN
      chk("misalign_clear", 32'(misalign), 32'd0);
`endif
      if ((k == d) && v.ld) begin
        chk("cdb_tag", 32'(cdb_tag), 32'(v.tag));
        chk("cdb_value", cdb_value, v.exp_val);
      end
      if (k == d + 1) begin
        chk("idle_tag", 32'(cdb_tag), 32'd0);
        chk("idle_value", cdb_value, 32'd0);
      end
    end
    start = 1'b0; mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
  endtask

  initial begin
    vec_t v;
    tbl[0] = mkv(1'b0, LS_STORE, MEM_WORD, 32'h1000, 32'h8, 32'hDEADBEEF, 32'h0, 6'd3,
                 32'h1008, 32'hDEADBEEF, 32'h0, 0, 0);
    tbl[1] = mkv(1'b1, LS_LOAD, MEM_BYTE, 32'h2000, 32'h3, 32'h0, 32'h00000080, 6'h15,
                 32'h2003, 32'h0, 32'hFFFFFF80, 0, 0);
    tbl[2] = mkv(1'b1, LS_LOADU, MEM_BYTE, 32'h2000, 32'h3, 32'h0, 32'h00000080, 6'h16,
                 32'h2003, 32'h0, 32'h00000080, 0, 0);
    tbl[3] = mkv(1'b0, LS_STORE, MEM_WORD, 32'h4000, 32'h10, 32'h12345678, 32'h0, 6'd7,
                 32'h4010, 32'h12345678, 32'h0, 3, 0);
    tbl[4] = mkv(1'b0, LS_STORE, MEM_BYTE, 32'h100, 32'hFFFFFFFF, 32'h000000A5, 32'h0, 6'd9,
                 32'h000000FF, 32'hA5A5A5A5, 32'h0, 1, 0);
    tbl[5] = mkv(1'b1, LS_LOAD, MEM_HALF, 32'h3000, 32'h2, 32'h0, 32'h00008001, 6'h2A,
                 32'h3002, 32'h0, 32'hFFFF8001, 0, 2);
    tbl[6] = mkv(1'b1, LS_LOADU, MEM_HALF, 32'h3000, 32'h0, 32'h0, 32'hFFFF7FFE, 6'h3F,
                 32'h3000, 32'h0, 32'h00007FFE, 2, 1);
    tbl[7] = mkv(1'b0, LS_STORE, MEM_HALF, 32'h20, 32'h2, 32'hCAFEBEEF, 32'h0, 6'd1,
                 32'h22, 32'hBEEFBEEF, 32'h0, 0, 0);

    reset = 1'b1; flush = 1'b0; start = 1'b1; insn_in = '0;
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_data = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_valid", 32'(mem_req_valid), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_cdb_valid", 32'(cdb_valid), 32'd0);
    chk("rst_cdb_tag", 32'(cdb_tag), 32'd0);
    chk("rst_cdb_value", cdb_value, 32'd0);
    cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    chk("rst_dominates_start", 32'(busy), 32'd0);

    for (int i = 0; i < 8; i++) run_txn(tbl[i], 1'b0);
    run_txn(tbl[3], 1'b1);

    for (int i = 0; i < 40; i++) begin
      logic [31:0] a;
      v.ld = 1'($urandom_range(1, 0));
      v.sz = mem_size_t'($urandom_range(2, 0));
      v.fn = v.ld ? (($urandom_range(1, 0) == 1) ? LS_LOADU : LS_LOAD) : LS_STORE;
      v.src1 = $urandom(); v.imm = $urandom(); v.src2 = $urandom(); v.resp = $urandom();
      v.tag = 6'($urandom());
      a = v.src1 + v.imm;
      v.imm = v.imm - (a % (32'd1 << int'(v.sz)));
      v.exp_addr = v.src1 + v.imm;
      v.exp_wdata = m_wdata(v.src2, v.sz);
      v.exp_val = m_load(v.resp, v.sz, v.fn == LS_LOADU);
      v.rdly = $urandom_range(3, 0); v.respdly = $urandom_range(3, 0);
      run_txn(v, 1'($urandom_range(1, 0)));
    end

    // Flush in WAIT, flush again in DRAIN, response two cycles after the first flush.
    begin_txn(tbl[1]);
    cyc(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    chk("wflush_busy", 32'(busy), 32'd1);
    cyc(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    chk("drain_flush_busy", 32'(busy), 32'd1);
    cyc(1'b0, 1'b1, 32'h80, 1'b0, 1'b0);
    chk("drain_busy", 32'(busy), 32'd1);
    chk("drain_done", 32'(done), 32'd0);
    cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    chk("drain_exit_busy", 32'(busy), 32'd0);
    chk("drain_exit_done", 32'(done), 32'd0);
    chk("drain_exit_cdb", 32'(cdb_valid), 32'd0);
    run_txn(tbl[0], 1'b0);

    // Reset asserted while waiting for a load response.
    begin_txn(tbl[5]);
    cyc(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    chk("rstw_valid", 32'(mem_req_valid), 32'd0);
    chk("rstw_write", 32'(mem_req_write), 32'd0);
    chk("rstw_addr", mem_req_addr, 32'd0);
    chk("rstw_wdata", mem_req_wdata, 32'd0);
    chk("rstw_size", 32'(mem_req_size), 32'd0);
    chk("rstw_done", 32'(done), 32'd0);
    chk("rstw_cdb", 32'(cdb_valid), 32'd0);
    chk("rstw_tag", 32'(cdb_tag), 32'd0);
    chk("rstw_value", cdb_value, 32'd0);
    chk("rstw_busy", 32'(busy), 32'd0);
    cyc(1'b0, 1'b1, 32'h55, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    chk("rstw_late_resp_done", 32'(done), 32'd0);

    // Flush in REQ for a load drops the request.
    begin_txn(tbl[1]);
    cyc(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    chk("lflush_valid_same", 32'(mem_req_valid), 32'd1);
    cyc(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    chk("lflush_valid_next", 32'(mem_req_valid), 32'd0);
    chk("lflush_busy", 32'(busy), 32'd0);

    // Flush in REQ for a store completes the handshake silently.
    begin_txn(tbl[0]);
    cyc(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    chk("sflush_valid", 32'(mem_req_valid), 32'd1);
    chk("sflush_addr", mem_req_addr, 32'h1008);
    cyc(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    chk("sflush_valid_hs", 32'(mem_req_valid), 32'd1);
    cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    chk("sflush_done", 32'(done), 32'd0);
    chk("sflush_busy", 32'(busy), 32'd0);

    // Flush in COMPLETE suppresses done.
    begin_txn(tbl[0]);
    cyc(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    chk("cflush_done", 32'(done), 32'd0);
    cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    chk("cflush_busy", 32'(busy), 32'd0);

    v = mkv(1'b1, LS_LOAD, MEM_WORD, 32'h1000, 32'h2, 32'h0, 32'h11223344, 6'd5,
            32'h1002, 32'h0, 32'h11223344, 0, 0);
`ifdef LS_UNIT_MISALIGN_CHECK_EN
    begin_txn(v);
    cyc(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    chk("mis_valid1", 32'(mem_req_valid), 32'd0);
    cyc(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    chk("mis_valid2", 32'(mem_req_valid), 32'd0);
    chk("mis_done", 32'(done), 32'd1);
    chk("mis_flag", 32'(misalign), 32'd1);
    cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    chk("mis_busy", 32'(busy), 32'd0);
`else
    run_txn(v, 1'b0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
